rom_port_arbiter: RTL and testbench

- Sequences the 4-byte-wide boot/program ROM and shares it between two requesters: instruction fetch (port F) and data load (port D).
- Accepts one request per transaction and drives the ROM address and read enable for one cycle.
- Captures the ROM's registered bytes and returns a 32-bit little-endian word with a valid or error response.
- Sits in the LSU between the fetch unit, the load path and the ROM.

---
 rtl/rom_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_rom_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the 4-byte-wide boot/program ROM between the
// instruction fetch port (F) and the data load port (D).
// One transaction per grant: latch request, issue one ROM read, capture the
// registered ROM bytes and return a little-endian word with valid/err.
// Build option: define ROM_ARB_RR_EN for round-robin arbitration on a tie;
// without it port D has fixed priority and no pointer register exists.
module rom_port_arbiter #(
    parameter logic [15:0] ROM_BASE  = 16'h8000,
    parameter int unsigned READ_SIZE = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic        f_valid,
    output logic        f_err,

    input  logic        d_req,
    input  logic [15:0] d_addr,
    output logic        d_ack,
    output logic        d_valid,
    output logic        d_err,

    output logic [31:0] rsp_data,

    output logic [15:0] rom_a,
    output logic        rom_re,
    input  logic [7:0]  rom_q0,
    input  logic [7:0]  rom_q1,
    input  logic [7:0]  rom_q2,
    input  logic [7:0]  rom_q3,

    output logic        busy
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    // Highest start address whose last byte still lies inside the ROM.
    localparam logic [AW-1:0] ROM_TOP = 16'hFFFF - AW'(READ_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_r;
    logic          err_r;
    logic          grant_d;
    // ROM bytes become valid one cycle after CAPTURE; this flag marks that cycle.
    logic          cap_pend;

`ifdef ROM_ARB_RR_EN
    // Tie-break pointer: 1 favours D, 0 favours F.
    logic          prefer_d;
`endif

    logic          any_req_c;
    logic          pick_d_c;
    logic [AW-1:0] sel_addr_c;
    logic          in_range_c;

    // Arbitration and range check of the request presented in IDLE.
    always_comb begin
        any_req_c = f_req | d_req;
`ifdef ROM_ARB_RR_EN
        pick_d_c  = d_req & (~f_req | prefer_d);
`else
        pick_d_c  = d_req;
`endif
        sel_addr_c = pick_d_c ? d_addr : f_addr;
        in_range_c = (sel_addr_c >= ROM_BASE) && (sel_addr_c <= ROM_TOP);
    end

    // Transaction sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_r   <= '0;
            err_r    <= 1'b0;
            grant_d  <= 1'b0;
            cap_pend <= 1'b0;
            f_ack    <= 1'b0;
            f_valid  <= 1'b0;
            f_err    <= 1'b0;
            d_ack    <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            rom_re   <= 1'b0;
            rom_a    <= '0;
            rsp_data <= '0;
            busy     <= 1'b0;
`ifdef ROM_ARB_RR_EN
            prefer_d <= 1'b0;
`endif
        end else begin
            // Single-cycle pulses default low.
            f_ack    <= 1'b0;
            d_ack    <= 1'b0;
            f_valid  <= 1'b0;
            d_valid  <= 1'b0;
            f_err    <= 1'b0;
            d_err    <= 1'b0;
            rom_re   <= 1'b0;
            cap_pend <= 1'b0;

            // Response for the previous transaction; overlaps the next IDLE.
            if (cap_pend) begin
                rsp_data <= err_r ? DW'(0) : {rom_q3, rom_q2, rom_q1, rom_q0};
                f_valid  <= ~grant_d;
                d_valid  <= grant_d;
                f_err    <= ~grant_d & err_r;
                d_err    <= grant_d & err_r;
            end

            case (state)
                IDLE: begin
                    busy <= any_req_c;
                    if (any_req_c) begin
                        grant_d <= pick_d_c;
                        addr_r  <= sel_addr_c;
                        err_r   <= ~in_range_c;
                        f_ack   <= ~pick_d_c;
                        d_ack   <= pick_d_c;
                        state   <= READ;
`ifdef ROM_ARB_RR_EN
                        prefer_d <= ~pick_d_c;
`endif
                    end
                end
                READ: begin
                    // Out-of-range requests never touch the ROM.
                    rom_a  <= addr_r;
                    rom_re <= ~err_r;
                    busy   <= 1'b1;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    cap_pend <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: randomized and directed bench for rom_port_arbiter
// with a transaction-level reference model and a byte-array ROM.
module tb_rom_port_arbiter;

    localparam int unsigned NCYC  = 4096;
    localparam int unsigned NRAND = 80;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        f_valid;
    logic        f_err;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_ack;
    logic        d_valid;
    logic        d_err;
    logic [31:0] rsp_data;
    logic [15:0] rom_a;
    logic        rom_re;
    logic [7:0]  rom_q0 = 8'h00;
    logic [7:0]  rom_q1 = 8'h00;
    logic [7:0]  rom_q2 = 8'h00;
    logic [7:0]  rom_q3 = 8'h00;
    logic        busy;

    rom_port_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_valid  (f_valid),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_ack    (d_ack),
        .d_valid  (d_valid),
        .d_err    (d_err),
        .rsp_data (rsp_data),
        .rom_a    (rom_a),
        .rom_re   (rom_re),
        .rom_q0   (rom_q0),
        .rom_q1   (rom_q1),
        .rom_q2   (rom_q2),
        .rom_q3   (rom_q3),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents and registered read port.
    logic [7:0] mem [65536];
    always @(posedge clk) begin
        if (rom_re) begin
            rom_q0 <= mem[rom_a];
            rom_q1 <= mem[16'(rom_a + 16'd1)];
            rom_q2 <= mem[16'(rom_a + 16'd2)];
            rom_q3 <= mem[16'(rom_a + 16'd3)];
        end
    end

    int          errors;
    int          checks;
    int          edge_n;
    int          cur_cyc;
    int          next_free;
    int          rsp_cnt;
    bit          prefer_d;
    bit          rand_gap;
    logic [31:0] cur_rsp;
    bit          f_held;
    bit          d_held;
    logic [15:0] f_a;
    logic [15:0] d_a;
    logic [15:0] qf [$];
    logic [15:0] qd [$];

    bit          exp_fack [NCYC];
    bit          exp_dack [NCYC];
    bit          exp_re   [NCYC];
    bit          exp_fv   [NCYC];
    bit          exp_dv   [NCYC];
    bit          exp_err  [NCYC];
    bit          exp_busy [NCYC];
    logic [15:0] exp_a    [NCYC];
    logic [31:0] exp_data [NCYC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cur_cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        int b;
        b = int'(a);
        return {mem[16'(b + 3)], mem[16'(b + 2)], mem[16'(b + 1)], mem[16'(b)]};
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] edges [6];
        edges[0] = 16'h7FFF; edges[1] = 16'h8000; edges[2] = 16'hFFFC;
        edges[3] = 16'hFFFD; edges[4] = 16'hFFFE; edges[5] = 16'hFFFF;
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 5)];
            1:       return 16'($urandom_range(32768, 65532));
            2:       return 16'($urandom());
            default: return 16'(32768 + $urandom_range(0, 15));
        endcase
    endfunction

    task automatic clear_exp(input int from);
        for (int i = from; i < int'(NCYC); i++) begin
            exp_fack[i] = 1'b0; exp_dack[i] = 1'b0; exp_re[i] = 1'b0;
            exp_fv[i] = 1'b0; exp_dv[i] = 1'b0; exp_err[i] = 1'b0;
            exp_busy[i] = 1'b0; exp_a[i] = 16'h0; exp_data[i] = 32'h0;
        end
    endtask

    // Reference: one grant per 3 cycles; ack +1, ROM read +2, response +4.
    task automatic model_edge(input int e);
        bit          pick_d;
        bit          err;
        logic [15:0] a;
        int          c;
        if (e < next_free || !(f_held || d_held)) return;
`ifdef ROM_ARB_RR_EN
        pick_d   = d_held && (!f_held || prefer_d);
        prefer_d = !pick_d;
`else
        pick_d   = d_held;
`endif
        a   = pick_d ? d_a : f_a;
        err = !((int'(a) >= 32768) && (int'(a) + 3 <= 65535));
        c   = e + 1;
        exp_fack[c]     = !pick_d;
        exp_dack[c]     = pick_d;
        exp_busy[c]     = 1'b1;
        exp_busy[c + 1] = 1'b1;
        exp_re[c + 1]   = !err;
        exp_a[c + 1]    = a;
        exp_fv[c + 3]   = !pick_d;
        exp_dv[c + 3]   = pick_d;
        exp_err[c + 3]  = err;
        exp_data[c + 3] = err ? 32'h0 : rom_word(a);
        next_free = e + 3;
    endtask

    task automatic check_cycle(input int c);
        cur_cyc = c;
        if (c >= int'(NCYC) - 8) begin
            errors++;
            $display("FAIL cycle_budget cyc=%0d got=over exp=under", c);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "cycle budget exhausted");
        end
        chk("f_ack",   32'(f_ack),   32'(exp_fack[c]));
        chk("d_ack",   32'(d_ack),   32'(exp_dack[c]));
        chk("rom_re",  32'(rom_re),  32'(exp_re[c]));
        if (exp_re[c]) chk("rom_a", 32'(rom_a), 32'(exp_a[c]));
        chk("f_valid", 32'(f_valid), 32'(exp_fv[c]));
        chk("d_valid", 32'(d_valid), 32'(exp_dv[c]));
        chk("f_err",   32'(f_err),   32'(exp_fv[c] && exp_err[c]));
        chk("d_err",   32'(d_err),   32'(exp_dv[c] && exp_err[c]));
        chk("busy",    32'(busy),    32'(exp_busy[c]));
        if (exp_fv[c] || exp_dv[c]) cur_rsp = exp_data[c];
        chk("rsp_data", rsp_data, cur_rsp);
        if (f_valid || d_valid) rsp_cnt++;
    endtask

    task automatic drive_ports(input int c);
        if (exp_fack[c]) f_held = 1'b0;
        if (exp_dack[c]) d_held = 1'b0;
        if (!f_held && qf.size() > 0 && (!rand_gap || $urandom_range(0, 2) == 0)) begin
            f_held = 1'b1;
            f_a    = qf.pop_front();
        end
        if (!d_held && qd.size() > 0 && (!rand_gap || $urandom_range(0, 2) == 0)) begin
            d_held = 1'b1;
            d_a    = qd.pop_front();
        end
        f_req  = f_held;
        d_req  = d_held;
        f_addr = f_held ? f_a : 16'($urandom());
        d_addr = d_held ? d_a : 16'($urandom());
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        e = edge_n;
        edge_n++;
        if (rst_n) model_edge(e);
        #1;
        check_cycle(edge_n);
        drive_ports(edge_n);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "f_ack"},   32'(f_ack),   32'h0);
        chk({pfx, "f_valid"}, 32'(f_valid), 32'h0);
        chk({pfx, "f_err"},   32'(f_err),   32'h0);
        chk({pfx, "d_ack"},   32'(d_ack),   32'h0);
        chk({pfx, "d_valid"}, 32'(d_valid), 32'h0);
        chk({pfx, "d_err"},   32'(d_err),   32'h0);
        chk({pfx, "rom_re"},  32'(rom_re),  32'h0);
        chk({pfx, "busy"},    32'(busy),    32'h0);
        chk({pfx, "rom_a"},   32'(rom_a),   32'h0);
        chk({pfx, "rsp"},     rsp_data,     32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_");
        clear_exp(edge_n);
        cur_rsp   = 32'h0;
        next_free = 0;
        prefer_d  = 1'b0;
        @(posedge clk);
        edge_n++;
        #1;
        check_cycle(edge_n);
        drive_ports(edge_n);
        rst_n = 1'b1;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((f_held || d_held || qf.size() > 0 || qd.size() > 0 || edge_n < next_free + 1)
               && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(n >= budget), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cur_cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; edge_n = 0; cur_cyc = 0; next_free = 0;
        rsp_cnt = 0; prefer_d = 1'b0; rand_gap = 1'b0; cur_rsp = 32'h0;
        f_held = 1'b0; d_held = 1'b0; f_a = 16'h0; d_a = 16'h0;
        f_req = 1'b0; d_req = 1'b0; f_addr = 16'h0; d_addr = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom());
        mem[16'h8000] = 8'h11; mem[16'h8001] = 8'h22; mem[16'h8002] = 8'h33;
        mem[16'h8003] = 8'h44; mem[16'h8004] = 8'h55;
        clear_exp(0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("init_");
        rst_n = 1'b1;

        // Single fetch with known ROM bytes.
        qf.push_back(16'h8000);
        drive_ports(edge_n);
        run_idle(40);
        chk("fetch_word", rsp_data, 32'h44332211);

        // Range boundaries on the data port.
        qd.push_back(16'h7FFF);
        qd.push_back(16'hFFFC);
        qd.push_back(16'hFFFD);
        drive_ports(edge_n);
        run_idle(60);

        // Contention: both ports held back-to-back for two requests each.
        do_reset();
        rsp_cnt = 0;
        qf.push_back(16'h8000); qf.push_back(16'h8008);
        qd.push_back(16'h8004); qd.push_back(16'h800C);
        drive_ports(edge_n);
        run_idle(60);
        chk("contention_rsp", 32'(rsp_cnt), 32'd4);

        // Back-to-back fetches, then a lone misaligned fetch.
        qf.push_back(16'h8000); qf.push_back(16'h8001); qf.push_back(16'h8002);
        drive_ports(edge_n);
        run_idle(60);
        qf.push_back(16'h8001);
        drive_ports(edge_n);
        run_idle(40);
        chk("misaligned", rsp_data, 32'h55443322);

        // Reset during READ: granted transaction dropped, the other re-arbitrated.
        do_reset();
        rsp_cnt = 0;
        qd.push_back(16'h8000);
        qf.push_back(16'h8008);
        drive_ports(edge_n);
        step();
        step();
        chk("re_before_rst", 32'(rom_re), 32'h1);
        do_reset();
        run_idle(40);
        chk("rsp_after_rst", 32'(rsp_cnt), 32'd1);

        // Randomized traffic on both ports.
        do_reset();
        rand_gap = 1'b1;
        for (int i = 0; i < int'(NRAND); i++) begin
            qf.push_back(rand_addr());
            qd.push_back(rand_addr());
        end
        drive_ports(edge_n);
        run_idle(2500);
        rand_gap = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
